dcache_store_buffer: RTL and testbench

//  Write-side companion to the instruction-fetch cache: holds retired stores from the MEM stage and drains them to data memory.

---
 rtl/dcache_pkg.sv | 25 ++
 rtl/sb_youngest_match.sv | 47 ++++
 rtl/dcache_store_buffer.sv | 155 +++++++++++++++
 tb/tb_dcache_store_buffer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and helpers for the data-cache store buffer
package dcache_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_BE_W   = SB_DATA_W / 8;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_DRAIN = 2'd1,
    SB_DONE  = 2'd2
  } sb_flush_e;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:2] addr;
    logic [SB_DATA_W-1:0] data;
    logic [SB_BE_W-1:0]   be;
  } sb_entry_t;

  function automatic logic be_full(input logic [SB_BE_W-1:0] be);
    return &be;
  endfunction

endpackage

// File: rtl/sb_youngest_match.sv
// rtl/sb_youngest_match.sv - picks the youngest set bit of a match vector, counting back from tail-1
module sb_youngest_match #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         i_match,
  input  logic [$clog2(DEPTH)-1:0] i_tail,
  output logic [DEPTH-1:0]         o_onehot,
  output logic                     o_any
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] w_rot;
  logic [DEPTH-1:0] w_pri;
  logic             w_found;

  // Rotate so bit 0 is the entry written most recently (tail-1), bit DEPTH-1 the oldest.
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_rot[k] = i_match[IDX_W'(int'(i_tail) - 1 - k)];
    end
  end

  always_comb begin
    w_pri   = '0;
    w_found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_rot[k] && !w_found) begin
        w_pri[k] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_pri[k]) begin
        o_onehot[IDX_W'(int'(i_tail) - 1 - k)] = 1'b1;
      end
    end
  end

  assign o_any = |i_match;

endmodule

// File: rtl/dcache_store_buffer.sv
// rtl/dcache_store_buffer.sv - in-order store buffer with load forwarding and fence drain
module dcache_store_buffer
  import dcache_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                st_valid,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [DATA_W/8-1:0] st_be,
  output logic                st_ready,
  input  logic                ld_check,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                fwd_hit,
  output logic [DATA_W-1:0]   fwd_data,
  output logic                fwd_conflict,
  output logic                mem_wr_valid,
  output logic [ADDR_W-1:0]   mem_wr_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic [DATA_W/8-1:0] mem_wr_be,
  input  logic                mem_wr_ready,
  input  logic                flush_req,
  output logic                flush_done,
  output logic                empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int BE_W  = DATA_W / 8;

  sb_entry_t        r_entries [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  sb_flush_e        r_state;
  logic             r_flush_done;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_tail_idx;
  logic [DEPTH-1:0] w_match;
  logic [DEPTH-1:0] w_young;
  logic             w_any;
  logic [DATA_W-1:0] w_sel_data;
  logic [BE_W-1:0]   w_sel_be;
  logic              w_unused;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];

  assign empty    = (r_head == r_tail);
  assign w_full   = (r_head[PTR_W-1] != r_tail[PTR_W-1]) && (w_head_idx == w_tail_idx);
  assign st_ready = !w_full && (r_state == SB_IDLE);
  assign w_push   = st_valid && st_ready;

  assign mem_wr_valid = !empty;
  assign w_pop        = mem_wr_valid && mem_wr_ready;

  assign mem_wr_addr = empty ? '0 : {r_entries[w_head_idx].addr, 2'b00};
  assign mem_wr_data = empty ? '0 : r_entries[w_head_idx].data;
  assign mem_wr_be   = empty ? '0 : r_entries[w_head_idx].be;

  // Sub-word address bits only matter for lane selection, which the caller already did.
  assign w_unused = ^{st_addr[1:0], ld_addr[1:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_head                        <= r_head + PTR_W'(1);
        r_entries[w_head_idx].valid   <= 1'b0;
      end
      if (w_push) begin
        r_entries[w_tail_idx] <= '{valid: 1'b1,
                                   addr:  st_addr[ADDR_W-1:2],
                                   data:  st_data,
                                   be:    st_be};
        r_tail                <= r_tail + PTR_W'(1);
      end
    end
  end

  // The entry leaving this cycle is still valid here, so a racing load sees it.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_entries[i].valid && (r_entries[i].addr == ld_addr[ADDR_W-1:2]);
    end
  end

  sb_youngest_match #(
    .DEPTH (DEPTH)
  ) u_youngest (
    .i_match  (w_match),
    .i_tail   (w_tail_idx),
    .o_onehot (w_young),
    .o_any    (w_any)
  );

  always_comb begin
    w_sel_data = '0;
    w_sel_be   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_young[i]) begin
        w_sel_data = r_entries[i].data;
        w_sel_be   = r_entries[i].be;
      end
    end
  end

  assign fwd_hit      = ld_check && w_any && be_full(w_sel_be);
  assign fwd_conflict = ld_check && w_any && !be_full(w_sel_be);
  assign fwd_data     = fwd_hit ? w_sel_data : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= SB_IDLE;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        SB_IDLE: begin
          if (flush_req) r_state <= SB_DRAIN;
        end
        SB_DRAIN: begin
          if (!flush_req) begin
            r_state <= SB_IDLE;
          end else if (empty) begin
            r_state      <= SB_DONE;
            r_flush_done <= 1'b1;
          end
        end
        SB_DONE: begin
          r_state <= SB_IDLE;
        end
        default: begin
          r_state <= SB_IDLE;
        end
      endcase
    end
  end

  assign flush_done = r_flush_done;

endmodule

// File: tb/tb_dcache_store_buffer.sv
// tb/tb_dcache_store_buffer.sv - self-checking bench for dcache_store_buffer
module tb_dcache_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [3:0]  st_be = '0;
  logic        st_ready;
  logic        ld_check = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        fwd_conflict;
  logic        mem_wr_valid;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_be;
  logic        mem_wr_ready = 1'b0;
  logic        flush_req = 1'b0;
  logic        flush_done;
  logic        empty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] w;
    logic [31:0] d;
    logic [3:0]  be;
  } st_t;

  st_t sb_q[$];
  bit  m_flush_busy = 1'b0;

  dcache_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_ready(st_ready),
    .ld_check(ld_check), .ld_addr(ld_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_conflict(fwd_conflict),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be), .mem_wr_ready(mem_wr_ready),
    .flush_req(flush_req), .flush_done(flush_done), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit m_ready();
    return (sb_q.size() < DEPTH) && !m_flush_busy;
  endfunction

  // Youngest store to the same word decides the load's fate.
  function automatic void m_fwd(input logic [31:0] a, output logic hit, output logic conf,
                                output logic [31:0] d);
    bit found = 1'b0;
    hit = 1'b0; conf = 1'b0; d = '0;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (!found && sb_q[i].w == a[31:2]) begin
        found = 1'b1;
        if (sb_q[i].be == 4'hF) begin hit = 1'b1; d = sb_q[i].d; end
        else conf = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    bit do_pop, do_push;
    do_pop  = (sb_q.size() > 0) && mem_wr_ready;
    do_push = st_valid && m_ready();
    @(posedge clk);
    if (do_pop) void'(sb_q.pop_front());
    if (do_push) sb_q.push_back('{st_addr[31:2], st_data, st_be});
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({st_ready, empty, mem_wr_valid, fwd_hit, fwd_conflict, flush_done} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 110000",
               {st_ready, empty, mem_wr_valid, fwd_hit, fwd_conflict, flush_done});
    end
    checks++;
    if ({mem_wr_addr, mem_wr_data, mem_wr_be, fwd_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h want zeros", mem_wr_addr, mem_wr_data, mem_wr_be, fwd_data);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: got ready=%b empty=%b want 1 1", st_ready, empty);
    end
    tick();
  endtask

  task automatic test_fill_drain();
    mem_wr_ready = 1'b0; st_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 32'h100 + 4 * i; st_data = $urandom;
      @(negedge clk);
      checks++;
      if (st_ready !== 1'b1) begin
        errors++; $display("FAIL fill_ready[%0d]: got %b want 1", i, st_ready);
      end
      tick();
    end
    st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", st_ready); end
    checks++;
    if (mem_wr_addr !== 32'h100) begin errors++; $display("FAIL full_head: got %h want 00000100", mem_wr_addr); end
    tick();
    mem_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h100 + 4 * i || mem_wr_data !== sb_q[0].d) begin
        errors++;
        $display("FAIL drain[%0d]: got v=%b a=%h d=%h want v=1 a=%h d=%h", i, mem_wr_valid,
                 mem_wr_addr, mem_wr_data, 32'h100 + 4 * i, sb_q[0].d);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (empty !== 1'b1 || mem_wr_valid !== 1'b0) begin
      errors++; $display("FAIL drained_empty: got empty=%b v=%b want 1 0", empty, mem_wr_valid);
    end
    mem_wr_ready = 1'b0;
    tick();
  endtask

  task automatic test_forward();
    logic eh, ec; logic [31:0] ed;
    mem_wr_ready = 1'b0;
    st_valid = 1'b1; st_addr = 32'h200; st_be = 4'hF; st_data = 32'hAAAA_AAAA; tick();
    st_data = 32'h5555_5555; tick();
    // Partial store pushed in the probe cycle must not be visible yet.
    st_data = $urandom; st_be = 4'h3;
    ld_check = 1'b1; ld_addr = 32'h202;
    @(negedge clk);
    checks++;
    if (fwd_hit !== 1'b1 || fwd_conflict !== 1'b0 || fwd_data !== 32'h5555_5555) begin
      errors++;
      $display("FAIL fwd_full: got hit=%b conf=%b d=%h want 1 0 55555555", fwd_hit, fwd_conflict, fwd_data);
    end
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fwd_hit !== 1'b0 || fwd_conflict !== 1'b1 || fwd_data !== 32'h0) begin
      errors++;
      $display("FAIL fwd_after_partial: got hit=%b conf=%b d=%h want 0 1 0", fwd_hit, fwd_conflict, fwd_data);
    end
    tick();
    ld_check = 1'b0;
    @(negedge clk);
    checks++;
    if (fwd_hit !== 1'b0 || fwd_conflict !== 1'b0) begin
      errors++; $display("FAIL fwd_no_check: got hit=%b conf=%b want 0 0", fwd_hit, fwd_conflict);
    end
    tick();
    ld_check = 1'b1; mem_wr_ready = 1'b1;
    for (int c = 0; c < 20 && sb_q.size() > 0; c++) begin
      @(negedge clk);
      m_fwd(ld_addr, eh, ec, ed);
      checks++;
      if (fwd_hit !== eh || fwd_conflict !== ec || fwd_data !== ed) begin
        errors++;
        $display("FAIL fwd_drain[%0d]: got %b %b %h want %b %b %h", c, fwd_hit, fwd_conflict, fwd_data, eh, ec, ed);
      end
      tick();
    end
    ld_check = 1'b0; mem_wr_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL fwd_drained: got empty=%b want 1", empty); end
    tick();
  endtask

  task automatic test_partial();
    mem_wr_ready = 1'b0;
    st_valid = 1'b1; st_addr = 32'h300; st_be = 4'hF; st_data = $urandom; tick();
    st_be = 4'h3; st_data = $urandom; tick();
    st_valid = 1'b0; ld_check = 1'b1; ld_addr = 32'h300;
    @(negedge clk);
    checks++;
    if (fwd_conflict !== 1'b1 || fwd_hit !== 1'b0) begin
      errors++; $display("FAIL partial_conf: got conf=%b hit=%b want 1 0", fwd_conflict, fwd_hit);
    end
    mem_wr_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (fwd_conflict !== 1'b1 || mem_wr_be !== 4'h3) begin
      errors++; $display("FAIL partial_popping: got conf=%b be=%h want 1 3", fwd_conflict, mem_wr_be);
    end
    tick();
    mem_wr_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (fwd_conflict !== 1'b0 || fwd_hit !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL partial_after_pop: got conf=%b hit=%b empty=%b want 0 0 1", fwd_conflict, fwd_hit, empty);
    end
    ld_check = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic eh, ec; logic [31:0] ed;
    mem_wr_ready = 1'b0;
    for (int c = 0; c < 8 && sb_q.size() < DEPTH; c++) begin
      st_valid = 1'b1; st_addr = 32'h400 + 4 * $urandom_range(0, 3);
      st_data = $urandom; st_be = 4'hF;
      tick();
    end
    for (int c = 0; c < 50; c++) begin
      st_valid     = (c == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      mem_wr_ready = (c == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      st_addr  = 32'h400 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3);
      st_data  = $urandom;
      st_be    = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
      ld_check = $urandom_range(0, 1);
      ld_addr  = 32'h400 + $urandom_range(0, 19);
      @(negedge clk);
      checks++;
      if (st_ready !== m_ready() || mem_wr_valid !== (sb_q.size() > 0) || empty !== (sb_q.size() == 0)) begin
        errors++;
        $display("FAIL b2b_flags[%0d]: got rdy=%b v=%b e=%b want %b %b %b", c, st_ready, mem_wr_valid,
                 empty, m_ready(), sb_q.size() > 0, sb_q.size() == 0);
      end
      if (sb_q.size() > 0) begin
        checks++;
        if (mem_wr_addr !== {sb_q[0].w, 2'b00} || mem_wr_data !== sb_q[0].d || mem_wr_be !== sb_q[0].be) begin
          errors++;
          $display("FAIL b2b_head[%0d]: got %h/%h/%h want %h/%h/%h", c, mem_wr_addr, mem_wr_data,
                   mem_wr_be, {sb_q[0].w, 2'b00}, sb_q[0].d, sb_q[0].be);
        end
      end
      m_fwd(ld_check ? ld_addr : 32'hFFFF_FFFF, eh, ec, ed);
      if (!ld_check) begin eh = 1'b0; ec = 1'b0; ed = '0; end
      checks++;
      if (fwd_hit !== eh || fwd_conflict !== ec || fwd_data !== ed) begin
        errors++;
        $display("FAIL b2b_fwd[%0d]: got %b %b %h want %b %b %h", c, fwd_hit, fwd_conflict, fwd_data, eh, ec, ed);
      end
      tick();
    end
    st_valid = 1'b0; ld_check = 1'b0; mem_wr_ready = 1'b1;
    for (int c = 0; c < 10 && sb_q.size() > 0; c++) tick();
    mem_wr_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (empty !== 1'b1 || sb_q.size() != 0) begin
      errors++; $display("FAIL b2b_final_empty: got empty=%b left=%0d want 1 0", empty, sb_q.size());
    end
    tick();
  endtask

  task automatic test_flush();
    int  empty_at = -1;
    int  pulses = 0;
    bit  exp_done, exp_ready;
    mem_wr_ready = 1'b0; st_be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 32'h500 + 4 * i; st_data = $urandom; tick();
    end
    st_valid = 1'b0; flush_req = 1'b1; mem_wr_ready = 1'b1;
    tick();
    m_flush_busy = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_done  = (empty_at >= 0) && (c == empty_at + 1);
      exp_ready = (empty_at >= 0) && (c >= empty_at + 2);
      checks++;
      if (flush_done !== exp_done || st_ready !== exp_ready || empty !== (sb_q.size() == 0)) begin
        errors++;
        $display("FAIL flush_cycle[%0d]: got done=%b rdy=%b empty=%b want %b %b %b", c, flush_done,
                 st_ready, empty, exp_done, exp_ready, sb_q.size() == 0);
      end
      if (flush_done === 1'b1) pulses++;
      if (empty_at < 0 && sb_q.size() == 0) empty_at = c;
      tick();
      if (exp_done) begin flush_req = 1'b0; m_flush_busy = 1'b0; end
    end
    flush_req = 1'b0; m_flush_busy = 1'b0;
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL flush_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_reset_mid_drain();
    mem_wr_ready = 1'b0; st_be = 4'hF;
    for (int i = 0; i < 2; i++) begin
      st_valid = 1'b1; st_addr = 32'h600 + 4 * i; st_data = $urandom; tick();
    end
    st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_wr_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", mem_wr_valid); end
    tick();
    mem_wr_ready = 1'b1;
    rstn = 1'b0;
    #1;
    checks++;
    if (mem_wr_valid !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL async_reset: got v=%b empty=%b want 0 1", mem_wr_valid, empty);
    end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (mem_wr_valid !== 1'b0 || st_ready !== 1'b1) begin
        errors++; $display("FAIL after_reset[%0d]: got v=%b rdy=%b want 0 1", c, mem_wr_valid, st_ready);
      end
      tick();
    end
    mem_wr_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_forward();
    test_partial();
    test_back_to_back();
    test_flush();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
